// File: rtl/dcache_req_stage_if.sv
// Request/compare bus of the data-cache request stage.
// The master side drives CPU requests and the compare-stage allowin; the
// slave side (the request stage) answers with req_ready and the beat fields.
interface dcache_req_stage_if #(
  parameter int INDEX_WD  = 6,
  parameter int OFFSET_WD = 4,
  parameter int TAG_WD    = 22,
  parameter int DATA_WD   = 64,
  parameter int WEN_WD    = 8
) ();
  localparam int ADDR_WD = TAG_WD + INDEX_WD + OFFSET_WD;

  // CPU request side
  logic                 req_valid;
  logic                 req_ready;
  logic [WEN_WD-1:0]    req_wen;
  logic [ADDR_WD-1:0]   req_addr;
  logic [DATA_WD-1:0]   req_wdata;

  // compare-stage side
  logic                 cmp_ready;
  logic                 out_valid;
  logic [TAG_WD-1:0]    out_tag;
  logic [INDEX_WD-1:0]  out_index;
  logic [OFFSET_WD-1:0] out_offset;
  logic [WEN_WD-1:0]    out_wen;
  logic [DATA_WD-1:0]   out_wdata;
  logic                 out_fence;
  logic                 out_fence_mode;
  logic                 out_fence_last;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, cmp_ready,
    input  req_ready, out_valid, out_tag, out_index, out_offset,
           out_wen, out_wdata, out_fence, out_fence_mode, out_fence_last
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, cmp_ready,
    output req_ready, out_valid, out_tag, out_index, out_offset,
           out_wen, out_wdata, out_fence, out_fence_mode, out_fence_last
  );
endinterface

// File: rtl/dcache_req_stage.sv
// Data-cache request/read stage.
// Splits CPU requests into tag/index/offset, drives the per-way SRAM read
// enables (active low) and the SRAM index with zero latency, and forwards the
// beat to the compare stage. A rising edge on fence_req starts a descending
// sweep over every line, issuing one fence beat per accepted cycle.
module dcache_req_stage #(
  parameter int WAYS      = 4,
  parameter int INDEX_WD  = 6,
  parameter int OFFSET_WD = 4,
  parameter int TAG_WD    = 22,
  parameter int DATA_WD   = 64,
  parameter int WEN_WD    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fence_req,
  input  logic                 fence_mode,
  output logic                 fence_busy,
  output logic                 fence_done,
  dcache_req_stage_if.slave    bus,
  output logic [WAYS-1:0]      sram_ren_n,
  output logic [INDEX_WD-1:0]  sram_addr
);
  localparam int ADDR_WD = TAG_WD + INDEX_WD + OFFSET_WD;
  localparam int CNT_WD  = INDEX_WD + 1;
  // Line count; the counter is one bit wider so it can hold LINES itself.
  localparam logic [CNT_WD-1:0] LINES = CNT_WD'(1) << INDEX_WD;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic                fence_req_q, fence_req_d;
  logic                mode_q, mode_d;
  logic                done_q, done_d;

  logic                rise_s;
  logic [CNT_WD-1:0]   cnt_m1_s;

  logic                out_valid_s;
  logic                req_ready_s;
  logic [TAG_WD-1:0]   out_tag_s;
  logic [INDEX_WD-1:0] out_index_s;
  logic [OFFSET_WD-1:0] out_offset_s;
  logic [WEN_WD-1:0]   out_wen_s;
  logic [DATA_WD-1:0]  out_wdata_s;
  logic                out_fence_s;
  logic                out_fence_mode_s;
  logic                out_fence_last_s;
  logic [WAYS-1:0]     sram_ren_n_s;

  // Address fields of the incoming CPU request.
  logic [TAG_WD-1:0]    req_tag_s;
  logic [INDEX_WD-1:0]  req_index_s;
  logic [OFFSET_WD-1:0] req_offset_s;

  assign req_tag_s    = bus.req_addr[ADDR_WD-1 -: TAG_WD];
  assign req_index_s  = bus.req_addr[OFFSET_WD +: INDEX_WD];
  assign req_offset_s = bus.req_addr[OFFSET_WD-1:0];

  assign rise_s   = fence_req & ~fence_req_q;
  assign cnt_m1_s = cnt_q - CNT_WD'(1);

  // Next-state logic: fence edge detection, sweep entry, beat countdown.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    done_d      = 1'b0;
    fence_req_d = fence_req;
    case (state_q)
      ST_IDLE: begin
        // A request accepted in the rise cycle still goes out normally;
        // the sweep owns the bus from the following cycle.
        if (rise_s) begin
          state_d = ST_SWEEP;
          cnt_d   = LINES;
          mode_d  = fence_mode;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        // Edges seen while sweeping are ignored; a stall holds the counter.
        if (bus.cmp_ready) begin
          if (cnt_q == CNT_WD'(1)) begin
            cnt_d   = {CNT_WD{1'b0}};
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_m1_s;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_WD{1'b0}};
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any sweep silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_WD{1'b0}};
      fence_req_q <= 1'b0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fence_req_q <= fence_req_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
    end
  end

  // Beat datapath: sweep beats while sweeping, otherwise pass the CPU request.
  always_comb begin
    out_valid_s      = 1'b0;
    req_ready_s      = 1'b0;
    out_tag_s        = {TAG_WD{1'b0}};
    out_index_s      = {INDEX_WD{1'b0}};
    out_offset_s     = {OFFSET_WD{1'b0}};
    out_wen_s        = {WEN_WD{1'b0}};
    out_wdata_s      = {DATA_WD{1'b0}};
    out_fence_s      = 1'b0;
    out_fence_mode_s = 1'b0;
    out_fence_last_s = 1'b0;
    if (state_q == ST_SWEEP) begin
      out_valid_s      = 1'b1;
      req_ready_s      = 1'b0;
      out_index_s      = cnt_m1_s[INDEX_WD-1:0];
      out_fence_s      = 1'b1;
      out_fence_mode_s = mode_q;
      out_fence_last_s = (cnt_q == CNT_WD'(1));
    end else begin
      out_valid_s      = bus.req_valid;
      req_ready_s      = bus.cmp_ready;
      out_tag_s        = req_tag_s;
      out_index_s      = req_index_s;
      out_offset_s     = req_offset_s;
      out_wen_s        = bus.req_wen;
      out_wdata_s      = bus.req_wdata;
    end
  end

  // SRAM read strobe: read only when the beat actually moves, so SRAM output
  // holds the stalled beat's data; never read while reset is asserted.
  always_comb begin
    if (out_valid_s && bus.cmp_ready && !reset) begin
      sram_ren_n_s = {WAYS{1'b0}};
    end else begin
      sram_ren_n_s = {WAYS{1'b1}};
    end
  end

  assign bus.out_valid      = out_valid_s;
  assign bus.req_ready      = req_ready_s;
  assign bus.out_tag        = out_tag_s;
  assign bus.out_index      = out_index_s;
  assign bus.out_offset     = out_offset_s;
  assign bus.out_wen        = out_wen_s;
  assign bus.out_wdata      = out_wdata_s;
  assign bus.out_fence      = out_fence_s;
  assign bus.out_fence_mode = out_fence_mode_s;
  assign bus.out_fence_last = out_fence_last_s;

  assign sram_ren_n = sram_ren_n_s;
  assign sram_addr  = out_index_s;
  assign fence_busy = (state_q == ST_SWEEP) & ~reset;
  assign fence_done = done_q & ~reset;

endmodule

// File: tb/tb_dcache_req_stage.sv
// Self-checking bench for dcache_req_stage: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_dcache_req_stage;
  localparam int WAYS = 4, IW = 6, OW = 4, TW = 22, DW = 64, WW = 8;
  localparam int AW = TW + IW + OW;
  localparam int LINES = 1 << IW;

  logic          clk = 1'b0;
  logic          reset;
  logic          fence_req;
  logic          fence_mode;
  logic          fence_busy;
  logic          fence_done;
  logic [WAYS-1:0] sram_ren_n;
  logic [IW-1:0] sram_addr;

  dcache_req_stage_if #(.INDEX_WD(IW), .OFFSET_WD(OW), .TAG_WD(TW),
                        .DATA_WD(DW), .WEN_WD(WW)) bus ();

  dcache_req_stage #(.WAYS(WAYS), .INDEX_WD(IW), .OFFSET_WD(OW), .TAG_WD(TW),
                     .DATA_WD(DW), .WEN_WD(WW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fence_req  (fence_req),
    .fence_mode (fence_mode),
    .fence_busy (fence_busy),
    .fence_done (fence_done),
    .bus        (bus.slave),
    .sram_ren_n (sram_ren_n),
    .sram_addr  (sram_addr)
  );

  always #5 clk = ~clk;

  // Reference model: the pending sweep is a queue of line indices.
  int   mq[$];
  bit   m_prev;
  bit   m_mode;
  bit   m_done;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt, beat_cnt, done_cnt, last_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rst_i, input bit fr, input bit fm, input bit rv,
                       input bit cr, input logic [WW-1:0] wen,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    reset         = rst_i;
    fence_req     = fr;
    fence_mode    = fm;
    bus.req_valid = rv;
    bus.cmp_ready = cr;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
  endtask

  // Compare every output with the model for the inputs currently driven.
  task automatic settle_check();
    bit sweeping;
    bit e_valid, e_ready, e_fence, e_last;
    logic [TW-1:0] e_tag;
    logic [IW-1:0] e_idx;
    logic [OW-1:0] e_off;
    logic [WW-1:0] e_wen;
    logic [DW-1:0] e_wd;
    logic [WAYS-1:0] e_ren;
    #2;
    sweeping = (mq.size() != 0);
    if (reset) begin
      chk("busy_rst", 64'(fence_busy), 64'd0);
      chk("done_rst", 64'(fence_done), 64'd0);
      chk("ren_rst", 64'(sram_ren_n), 64'hF);
    end else begin
      if (sweeping) begin
        e_valid = 1'b1; e_ready = 1'b0; e_fence = 1'b1;
        e_last  = (mq.size() == 1);
        e_idx   = IW'(mq[0]);
        e_tag = '0; e_off = '0; e_wen = '0; e_wd = '0;
      end else begin
        e_valid = bus.req_valid; e_ready = bus.cmp_ready;
        e_fence = 1'b0; e_last = 1'b0;
        e_tag = bus.req_addr / (1 << (IW + OW));
        e_idx = IW'((bus.req_addr / (1 << OW)) % LINES);
        e_off = OW'(bus.req_addr % (1 << OW));
        e_wen = bus.req_wen; e_wd = bus.req_wdata;
      end
      e_ren = (e_valid && bus.cmp_ready) ? 4'h0 : 4'hF;
      chk("busy", 64'(fence_busy), 64'(sweeping));
      chk("done", 64'(fence_done), 64'(m_done));
      chk("valid", 64'(bus.out_valid), 64'(e_valid));
      chk("ready", 64'(bus.req_ready), 64'(e_ready));
      chk("fence", 64'(bus.out_fence), 64'(e_fence));
      chk("last", 64'(bus.out_fence_last), 64'(e_last));
      chk("sram_addr", 64'(sram_addr), 64'(e_idx));
      chk("index", 64'(bus.out_index), 64'(e_idx));
      chk("ren_n", 64'(sram_ren_n), 64'(e_ren));
      if (e_valid) begin
        chk("tag", 64'(bus.out_tag), 64'(e_tag));
        chk("offset", 64'(bus.out_offset), 64'(e_off));
        chk("wen", 64'(bus.out_wen), 64'(e_wen));
        chk("wdata", bus.out_wdata, e_wd);
      end
      if (sweeping) chk("mode", 64'(bus.out_fence_mode), 64'(m_mode));
      if (fence_busy) busy_cnt++;
      if (fence_done) done_cnt++;
      if (bus.out_valid && bus.out_fence && bus.cmp_ready) beat_cnt++;
      if (bus.out_valid && bus.out_fence_last && bus.cmp_ready) last_cnt++;
    end
  endtask

  // Advance the model across a clock edge using the inputs driven this cycle.
  task automatic tick();
    bit nd;
    @(posedge clk);
    if (reset) begin
      mq.delete(); m_prev = 1'b0; m_mode = 1'b0; m_done = 1'b0;
    end else begin
      nd = 1'b0;
      if (mq.size() != 0) begin
        if (bus.cmp_ready) begin
          void'(mq.pop_front());
          if (mq.size() == 0) nd = 1'b1;
        end
      end else if (fence_req && !m_prev) begin
        m_mode = fence_mode;
        for (int i = LINES - 1; i >= 0; i--) mq.push_back(i);
      end
      m_prev = fence_req;
      m_done = nd;
    end
    #1;
  endtask

  task automatic cyc(input bit rst_i, input bit fr, input bit fm, input bit rv,
                     input bit cr, input logic [WW-1:0] wen,
                     input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    drive(rst_i, fr, fm, rv, cr, wen, addr, wd);
    settle_check();
    tick();
  endtask

  task automatic clr_cnt();
    busy_cnt = 0; beat_cnt = 0; done_cnt = 0; last_cnt = 0;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int hold;
    bit fr_r;
    m_prev = 1'b0; m_mode = 1'b0; m_done = 1'b0;
    clr_cnt();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;

    // Reset
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '0);

    // Load handshake
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 32'h0000_0A5C, 64'h0);
    settle_check();
    chk("ld_ren", 64'(sram_ren_n), 64'h0);
    chk("ld_addr", 64'(sram_addr), 64'h25);
    chk("ld_off", 64'(bus.out_offset), 64'hC);
    chk("ld_ready", 64'(bus.req_ready), 64'h1);
    tick();

    // Stall for 3 cycles, then a single issue
    a = AW'($urandom); d = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, a, d);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, a, d);

    // Full sweep, invalidate-only
    clr_cnt();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, '0, '0, '0);
    for (int i = 0; i < LINES + 6; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'(i % 2), 1'b1, '0, AW'($urandom), '0);
    chk("sweep_beats", 64'(beat_cnt), 64'(LINES));
    chk("sweep_busy", 64'(busy_cnt), 64'(LINES));
    chk("sweep_done", 64'(done_cnt), 64'd1);
    chk("sweep_last", 64'(last_cnt), 64'd1);

    // Sweep back-pressure at index 40, writeback+invalidate
    clr_cnt();
    hold = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    for (int i = 0; i < LINES + 20; i++) begin
      if (mq.size() != 0 && mq[0] == 40 && hold < 5) begin
        hold++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        settle_check();
        chk("bp_addr", 64'(sram_addr), 64'd40);
        tick();
      end else begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
      end
    end
    chk("bp_beats", 64'(beat_cnt), 64'(LINES));
    chk("bp_busy", 64'(busy_cnt), 64'(LINES + 5));
    chk("bp_done", 64'(done_cnt), 64'd1);

    // Fence rise together with a request, second rise mid-sweep ignored
    clr_cnt();
    a = AW'($urandom); d = {$urandom, $urandom};
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0F, a, d);
    settle_check();
    chk("sim_fence", 64'(bus.out_fence), 64'd0);
    chk("sim_ready", 64'(bus.req_ready), 64'd1);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0F, a, d);
    settle_check();
    chk("sim_ready_sweep", 64'(bus.req_ready), 64'd0);
    tick();
    for (int i = 0; i < LINES + 6; i++)
      cyc(1'b0, !(i >= 20 && i < 25), 1'b0, 1'b1, 1'b1, '0, a, d);
    chk("rep_beats", 64'(beat_cnt), 64'(LINES));
    chk("rep_busy", 64'(busy_cnt), 64'(LINES));
    chk("rep_done", 64'(done_cnt), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);

    // Reset at sweep index 20
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    for (int i = 0; i < LINES + 4; i++) begin
      if (mq.size() != 0 && mq[0] == 20) break;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    end
    chk("rst_reached_20", 64'(mq.size()), 64'd21);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    clr_cnt();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 32'h1234_5678, 64'h0);
    settle_check();
    chk("rst_busy", 64'(fence_busy), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    tick();
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0, AW'($urandom), '0);
    chk("rst_no_done", 64'(done_cnt), 64'd0);

    // Randomized traffic
    fr_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) fr_r = ~fr_r;
      cyc(($urandom_range(0, 299) == 0), fr_r, 1'($urandom), 1'($urandom),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 1) == 0) ? WW'(0) : WW'($urandom),
          AW'($urandom), {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
